bcd_seg7_scan: RTL and testbench
================================

Name: bcd_seg7_scan

Overview:
- Downstream consumer of the 8-bit binary-to-BCD stage.
- Takes a 12-bit, 3-digit packed BCD value on a load strobe and double-buffers it.
- Drives a time-multiplexed 3-digit common-anode 7-segment display on the board.
- New values are committed only at a frame boundary, so a digit never tears mid-scan.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (legal range ≥2); prescaler width is $clog2(SCAN_DIV).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- bcd_in  in  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- load  in  1  one-cycle strobe; captures bcd_in into the pending buffer.
- blank  in  1  level; forces all anodes inactive.
- pending  out  1  high while a loaded value awaits commit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  3  digit anodes, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - Prescaler, digit index and pend_reg = 0.
  - disp_reg = 12'h000; pending = 0.
  - seg = 7'h7F; an = 3'b111.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick is asserted in the cycle the count equals SCAN_DIV-1.
- Digit index:
  - Advances 0→1→2→0 on tick; the index is held when tick is low.
  - Frame wrap = a tick while index==2.
- Load:
  - On load, pend_reg <= bcd_in and pending <= 1.
  - A load while pending is already set overwrites pend_reg (last value wins).
- Commit:
  - On frame wrap with pending=1: disp_reg <= pend_reg and pending <= 0.
  - If load coincides with a commit, the commit uses the old pend_reg. pend_reg takes the new value and pending stays 1.
- Outputs: registered, one-cycle latency from index/disp_reg.
  - an = ~(1<<index), or 3'b111 when blank=1.
  - seg = decode(disp_reg nibble[index]).
  - blank does not stop the prescaler, the index or the commit logic.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Nibble A–F (invalid BCD) → dash 3F (g only).
- Reset mid-frame: all state returns immediately to reset values and the pending value is discarded.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - Hundreds digit shows seg=7F when its nibble is 0.
  - Tens digit shows seg=7F when both hundreds and tens nibbles are 0.
  - Ones digit is never blanked; anodes still scan normally.
- Undefined: all three digits are always decoded, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=3.
  - SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - The 10-entry active-low digit pattern constants.
  - The digit-index typedef (2 bits).
- One combinational sub-module, seg7_decode: 4-bit nibble in, 7-bit active-low pattern out, invalid→dash. It is reusable by other display paths.

Test Plan (SCAN_DIV=4):
- Reset/idle: release rst_n with disp=000.
  - an sequence is 110, 101, 011, each held 4 clks.
  - Without LZB, seg=40 on every digit. With SEG7_LZB_EN, seg=40 only while an=110; otherwise 7F.
- Load mid-frame: load bcd_in=12'h255 while index=1.
  - pending=1 immediately; display stays 000 until the frame-wrap tick, where pending→0.
  - Next frame: an=110/seg=12, an=101/seg=12, an=011/seg=24.
- Overwrite: load 12'h123, then 12'h208 before wrap.
  - Frame shows ones=00 (8), tens=40 (0), hundreds=24 (2); with LZB, tens is still 40.
  - 123 never appears.
- Coincident load/commit: pending holds 12'h111; load 12'h999 on the wrap tick.
  - Frame shows 111 (79 on all digits) and pending stays 1.
  - Following frame shows 999 (seg=10).
- Invalid and blank:
  - load 12'h1A3 → tens slot seg=3F.
  - Assert blank → an=111 next clk while the index keeps advancing.
  - Deassert blank → an resumes at the current index.
- Reset mid-frame: assert rst_n=0 with pending=1 at index=2.
  - Immediately seg=7F, an=111, pending=0.
  - After release, display shows 000 (disp_reg was reset).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 3-digit 7-segment display path.
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic [1:0] {
    DIG_ONES  = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNDS = 2'd2
  } digit_idx_t;

  // Selects the BCD nibble shown in a given digit slot.
  function automatic logic [3:0] digit_nibble(input logic [11:0] value, input digit_idx_t idx);
    logic [3:0] nib;
    case (idx)
      DIG_ONES:  nib = value[3:0];
      DIG_TENS:  nib = value[7:4];
      DIG_HUNDS: nib = value[11:8];
      default:   nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-BCD codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pattern lookup; A-F fall through to the dash.
  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Double-buffered 3-digit BCD scanner for a common-anode 7-segment display (SCAN_DIV >= 2).
// Define SEG7_LZB_EN to blank leading zeros on the hundreds and tens digits.
module bcd_seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [11:0]           bcd_in,
  input  logic                  load,
  input  logic                  blank,
  output logic                  pending,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0]         pre_q, pre_d;
  digit_idx_t            idx_q, idx_d;
  logic [11:0]           pend_q, pend_d;
  logic                  pending_q, pending_d;
  logic [11:0]           disp_q, disp_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic       tick_s;
  logic       wrap_s;
  logic [3:0] nib_s;
  logic [6:0] dec_s;

  assign tick_s = (pre_q == PRE_LAST);
  assign wrap_s = tick_s && (idx_q == DIG_HUNDS);

  // Prescaler: one tick per digit slot.
  always_comb begin
    pre_d = pre_q;
    if (tick_s) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_ONE;
    end
  end

  // Digit index walks ones -> tens -> hundreds, advancing only on tick.
  always_comb begin
    idx_d = idx_q;
    case (idx_q)
      DIG_ONES:  idx_d = tick_s ? DIG_TENS  : DIG_ONES;
      DIG_TENS:  idx_d = tick_s ? DIG_HUNDS : DIG_TENS;
      DIG_HUNDS: idx_d = tick_s ? DIG_ONES  : DIG_HUNDS;
      default:   idx_d = DIG_ONES;
    endcase
  end

  // Commit reads the old pending value, so a coincident load is kept for the next frame.
  always_comb begin
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (wrap_s && pending_q) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end else begin
      disp_d    = disp_q;
    end
    if (load) begin
      pend_d    = bcd_in;
      pending_d = 1'b1;
    end else begin
      pend_d    = pend_q;
    end
  end

  assign nib_s = digit_nibble(disp_q, idx_q);

  seg7_decode u_decode (
    .nibble_i (nib_s),
    .seg_o    (dec_s)
  );

  // Segment pattern for the current slot, with optional leading-zero blanking.
  always_comb begin
    seg_d = dec_s;
`ifdef SEG7_LZB_EN
    if ((idx_q == DIG_HUNDS) && (disp_q[11:8] == 4'h0)) begin
      seg_d = SEG_BLANK;
    end else if ((idx_q == DIG_TENS) && (disp_q[11:4] == 8'h00)) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_s;
    end
`else
    seg_d = dec_s;
`endif
  end

  // Anode select; blank only masks the anodes, scanning carries on underneath.
  always_comb begin
    an_d = 3'b111;
    if (blank) begin
      an_d = 3'b111;
    end else begin
      case (idx_q)
        DIG_ONES:  an_d = 3'b110;
        DIG_TENS:  an_d = 3'b101;
        DIG_HUNDS: an_d = 3'b011;
        default:   an_d = 3'b111;
      endcase
    end
  end

  // Scan timing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= DIG_ONES;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end

  // Pending and display buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 12'h000;
      pending_q <= 1'b0;
      disp_q    <= 12'h000;
    end else begin
      pend_q    <= pend_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
    end
  end

  // Registered display drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= 3'b111;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign pending = pending_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan with SCAN_DIV=4; honours SEG7_LZB_EN when defined.
module tb_bcd_seg7_scan;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        load;
  logic        blank;
  logic        pending;
  logic [6:0]  seg;
  logic [2:0]  an;

  int checks;
  int errors;

  // Reference model: time since reset as a plain cycle count, plus the two buffers.
  int          n;
  logic [11:0] m_pend;
  logic        m_pending;
  logic [11:0] m_disp;
  logic [6:0]  m_seg;
  logic [2:0]  m_an;

  logic [6:0] pat [0:9];

  bcd_seg7_scan #(.SCAN_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bcd_in  (bcd_in),
    .load    (load),
    .blank   (blank),
    .pending (pending),
    .seg     (seg),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pattern(input logic [11:0] v, input int d);
    logic [3:0] nib;
    logic [6:0] p;
    nib = 4'((v >> (4 * d)) & 12'h00F);
    p = (nib <= 4'd9) ? pat[nib] : 7'h3F;
`ifdef SEG7_LZB_EN
    if (d == 2 && v[11:8] == 4'h0) p = 7'h7F;
    if (d == 1 && v[11:4] == 8'h00) p = 7'h7F;
`endif
    return p;
  endfunction

  task automatic model_reset();
    n = 0;
    m_pend = 12'h000;
    m_pending = 1'b0;
    m_disp = 12'h000;
    m_seg = 7'h7F;
    m_an = 3'b111;
  endtask

  task automatic model_step();
    int  slot;
    int  d;
    logic wrap;
    slot = n % DIV;
    d = (n / DIV) % 3;
    m_an = blank ? 3'b111 : (3'b111 & ~(3'b001 << d));
    m_seg = digit_pattern(m_disp, d);
    wrap = (slot == DIV - 1) && (d == 2);
    if (wrap && m_pending) begin
      m_disp = m_pend;
      m_pending = 1'b0;
    end
    if (load) begin
      m_pend = bcd_in;
      m_pending = 1'b1;
    end
    n = n + 1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model at the edge, compare every output at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    chk("seg", {5'd0, seg}, {5'd0, m_seg});
    chk("an", {9'd0, an}, {9'd0, m_an});
    chk("pending", {11'd0, pending}, {11'd0, m_pending});
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  // Advance until the next edge will act on digit slot d at prescaler count p.
  task automatic goto_slot(input int d, input int p);
    int guard;
    guard = 0;
    while (!((n % DIV) == p && ((n / DIV) % 3) == d) && guard < 3 * DIV + 2) begin
      cyc();
      guard++;
    end
    if (!((n % DIV) == p && ((n / DIV) % 3) == d)) begin
      errors++;
      $display("FAIL goto_slot: slot %0d/%0d not reached in cycle budget", d, p);
    end
  endtask

  task automatic do_load(input logic [11:0] v);
    bcd_in = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
    pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    load = 1'b0;
    blank = 1'b0;
    bcd_in = 12'h000;
    model_reset();

    run(2);
    chk("reset_seg", {5'd0, seg}, 12'h07F);
    chk("reset_an", {9'd0, an}, 12'h007);
    chk("reset_pending", {11'd0, pending}, 12'h000);

    rst_n = 1'b1;
    cyc();
    chk("idle_an0", {9'd0, an}, 12'h006);
    chk("idle_seg0", {5'd0, seg}, 12'h040);
    run(3 * DIV + 2);

    // Load mid-frame, committed at the next wrap.
    goto_slot(1, 0);
    do_load(12'h255);
    chk("load_pending", {11'd0, pending}, 12'h001);
    goto_slot(0, 0);
    chk("commit_pending", {11'd0, pending}, 12'h000);
    cyc();
    chk("f255_an0", {9'd0, an}, 12'h006);
    chk("f255_seg0", {5'd0, seg}, 12'h012);
    run(DIV);
    chk("f255_seg1", {5'd0, seg}, 12'h012);
    run(DIV);
    chk("f255_an2", {9'd0, an}, 12'h003);
    chk("f255_seg2", {5'd0, seg}, 12'h024);

    // Overwrite before wrap: last value wins.
    goto_slot(0, 1);
    do_load(12'h123);
    run(2);
    do_load(12'h208);
    goto_slot(0, 0);
    cyc();
    chk("f208_seg0", {5'd0, seg}, 12'h000);
    run(DIV);
    chk("f208_seg1", {5'd0, seg}, 12'h040);
    run(DIV);
    chk("f208_seg2", {5'd0, seg}, 12'h024);

    // Load coincident with the commit tick.
    goto_slot(1, 0);
    do_load(12'h111);
    goto_slot(2, DIV - 1);
    do_load(12'h999);
    chk("coinc_pending", {11'd0, pending}, 12'h001);
    cyc();
    chk("f111_seg0", {5'd0, seg}, 12'h079);
    run(2 * DIV);
    chk("f111_seg2", {5'd0, seg}, 12'h079);
    goto_slot(0, 0);
    chk("f999_pending", {11'd0, pending}, 12'h000);
    cyc();
    chk("f999_seg0", {5'd0, seg}, 12'h010);

    // Invalid nibble shows a dash, then blank masks anodes.
    do_load(12'h1A3);
    goto_slot(0, 0);
    cyc();
    run(DIV);
    chk("dash_seg1", {5'd0, seg}, 12'h03F);
    blank = 1'b1;
    cyc();
    chk("blank_an", {9'd0, an}, 12'h007);
    run(5);
    blank = 1'b0;
    run(3 * DIV);

    // Reset mid-frame with a value pending.
    do_load(12'h321);
    goto_slot(2, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_seg", {5'd0, seg}, 12'h07F);
    chk("rst_an", {9'd0, an}, 12'h007);
    chk("rst_pending", {11'd0, pending}, 12'h000);
    model_reset();
    run(2);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_an0", {9'd0, an}, 12'h006);
    chk("post_rst_seg0", {5'd0, seg}, 12'h040);
    run(3 * DIV);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bcd_in = 12'($urandom);
      if ($urandom_range(0, 3) == 0) bcd_in[11:8] = 4'h0;
      if ($urandom_range(0, 5) == 0) bcd_in[11:4] = 8'h00;
      load = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      cyc();
    end
    load = 1'b0;
    blank = 1'b0;
    run(3 * DIV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
